// File: rtl/pipe_stage_monitor.sv
// Debug monitor for a two-register pipeline stage (b -> c). It checks that c
// trails b by exactly one enabled edge, counts failures and classifies the stage.
module pipe_stage_monitor #(
  parameter int WIDTH        = 4,
  parameter int CNT_W        = 8,
  parameter int PRIME_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] check_cnt,
  output logic [1:0]       mode,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PRIME = 2'b01,
    S_CHECK = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       PRIME_LAST = 4'(PRIME_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       prime_cnt_q, prime_cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] check_cnt_q, check_cnt_d;
  logic             seen_nb_q, seen_nb_d;
  logic             seen_bk_q, seen_bk_d;
  logic             nb_hit, bk_hit;

  // b_q still holds the previous edge's b here, which is what a
  // nonblocking pipeline's second register must present on c.
  assign nb_hit = (c == b_q);
  assign bk_hit = (c == b);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path can infer a latch.
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    b_d         = en ? b : b_q;
    mismatch_d  = 1'b0;
    err_cnt_d   = err_cnt_q;
    check_cnt_d = check_cnt_q;
    seen_nb_d   = seen_nb_q;
    seen_bk_d   = seen_bk_q;

    if (clr) begin
      state_d     = en ? S_PRIME : S_IDLE;
      prime_cnt_d = '0;
      err_cnt_d   = '0;
      check_cnt_d = '0;
      seen_nb_d   = 1'b0;
      seen_bk_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (en) begin
            state_d     = S_PRIME;
            prime_cnt_d = '0;
          end
        end
        S_PRIME: begin
          if (!en)                           state_d     = S_IDLE;
          else if (prime_cnt_q == PRIME_LAST) state_d     = S_CHECK;
          else                               prime_cnt_d = prime_cnt_q + 4'd1;
        end
        S_CHECK: begin
          if (!en) begin
            state_d = S_IDLE;
          end else begin
            mismatch_d = !nb_hit;
            if (check_cnt_q != CNT_MAX)           check_cnt_d = check_cnt_q + CNT_ONE;
            if (!nb_hit && err_cnt_q != CNT_MAX)  err_cnt_d   = err_cnt_q + CNT_ONE;
            seen_nb_d = seen_nb_q | !nb_hit;
            seen_bk_d = seen_bk_q | !bk_hit;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, exactly like the pipeline being monitored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      prime_cnt_q <= '0;
      b_q         <= '0;
      mismatch_q  <= 1'b0;
      err_cnt_q   <= '0;
      check_cnt_q <= '0;
      seen_nb_q   <= 1'b0;
      seen_bk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      b_q         <= b_d;
      mismatch_q  <= mismatch_d;
      err_cnt_q   <= err_cnt_d;
      check_cnt_q <= check_cnt_d;
      seen_nb_q   <= seen_nb_d;
      seen_bk_q   <= seen_bk_d;
    end
  end

  assign mismatch  = mismatch_q;
  assign err_cnt   = err_cnt_q;
  assign check_cnt = check_cnt_q;
  assign mode      = {seen_nb_q, seen_bk_q};
  assign state     = state_q;

endmodule

// File: tb/tb_pipe_stage_monitor.sv
// Directed bench for pipe_stage_monitor: two instances (CNT_W=8 and CNT_W=3)
// share stimulus and are checked every cycle against a run-length based model.
module tb_pipe_stage_monitor;

  localparam int W = 4;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] c   = '0;

  logic       mis8, mis3;
  logic [7:0] err8, chk8;
  logic [2:0] err3, chk3;
  logic [1:0] mode8, mode3, st8, st3;

  int total = 0;
  int bad   = 0;

  pipe_stage_monitor #(.WIDTH(W), .CNT_W(8), .PRIME_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .b(b), .c(c),
    .mismatch(mis8), .err_cnt(err8), .check_cnt(chk8), .mode(mode8), .state(st8)
  );

  pipe_stage_monitor #(.WIDTH(W), .CNT_W(3), .PRIME_CYCLES(P)) dut_s (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .b(b), .c(c),
    .mismatch(mis3), .err_cnt(err3), .check_cnt(chk3), .mode(mode3), .state(st3)
  );

  always #40 clk = ~clk;

  // Model: run = consecutive enabled edges since the monitor was (re)activated.
  int           m_run = 0;
  int           m_err = 0;
  int           m_chk = 0;
  bit           m_nb  = 0;
  bit           m_bk  = 0;
  bit           m_mis = 0;
  logic [W-1:0] m_bq  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_err = 0; m_chk = 0; m_nb = 0; m_bk = 0; m_mis = 0; m_bq = '0;
    end else begin
      if (clr) begin
        m_err = 0; m_chk = 0; m_nb = 0; m_bk = 0; m_mis = 0;
        m_run = en ? 1 : 0;
      end else begin
        m_mis = 0;
        if (en && m_run > P) begin
          m_mis = (c != m_bq);
          m_chk++;
          if (m_mis) m_err++;
          m_nb = m_nb | m_mis;
          m_bk = m_bk | (c != b);
        end
        if (!en)            m_run = 0;
        else if (m_run <= P) m_run++;
      end
      if (en) m_bq = b;
    end
  end

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int exp_state();
    if (m_run == 0) return 0;
    if (m_run <= P) return 1;
    return 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("state8", 32'(st8), 32'(exp_state()));
    check("state3", 32'(st3), 32'(exp_state()));
    check("mismatch8", 32'(mis8), 32'(m_mis));
    check("mismatch3", 32'(mis3), 32'(m_mis));
    check("mode8", 32'(mode8), 32'({m_nb, m_bk}));
    check("mode3", 32'(mode3), 32'({m_nb, m_bk}));
    check("err8", 32'(err8), 32'(sat(m_err, 255)));
    check("chk8", 32'(chk8), 32'(sat(m_chk, 255)));
    check("err3", 32'(err3), 32'(sat(m_err, 7)));
    check("chk3", 32'(chk3), 32'(sat(m_chk, 7)));
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) compare_all();
  end

  // Drive one edge's inputs at the falling edge, then stop just past the rising edge.
  task automatic step(input logic e, input logic cl, input logic [W-1:0] bv, input logic [W-1:0] cv);
    @(negedge clk);
    en = e; clr = cl; b = bv; c = cv;
    @(posedge clk);
    #2;
  endtask

  logic [W-1:0] seq [8] = '{4'h3, 4'h7, 4'hF, 4'hA, 4'h2, 4'h2, 4'h2, 4'h2};

  initial begin
    #1 rst = 1'b1;
    #10;
    check("rst_state", 32'(st8), 0);
    check("rst_err", 32'(err8), 0);
    check("rst_chk", 32'(chk8), 0);
    check("rst_mode", 32'(mode8), 0);
    check("rst_mis", 32'(mis8), 0);
    #10 rst = 1'b0;

    // Nonblocking-consistent stream: c trails b by one edge.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, seq[k], (k == 0) ? 4'h0 : seq[k-1]);
      if (k == 0) check("nb_E0_prime", 32'(st8), 1);
      if (k == 1) check("nb_E1_prime", 32'(st8), 1);
      if (k == 2) check("nb_E2_check", 32'(st8), 2);
      if (k >= 3) check("nb_no_mis", 32'(mis8), 0);
    end
    check("nb_err", 32'(err8), 0);
    check("nb_chk", 32'(chk8), 5);
    check("nb_mode", 32'(mode8), 1);

    step(1'b0, 1'b0, 4'h2, 4'h2);
    check("nb_endrop_state", 32'(st8), 0);
    check("nb_endrop_chk", 32'(chk8), 5);
    step(1'b0, 1'b1, 4'h2, 4'h2);
    check("clr_idle_chk", 32'(chk8), 0);
    check("clr_idle_state", 32'(st8), 0);

    // Blocking-consistent stream: c equals b on the same edge.
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b0, seq[k], seq[k]);
      if (k == 3) check("bk_E3_mis", 32'(mis8), 1);
      if (k == 4) check("bk_E4_mis", 32'(mis8), 1);
      if (k == 5) check("bk_E5_mis", 32'(mis8), 0);
    end
    check("bk_err", 32'(err8), 2);
    check("bk_chk", 32'(chk8), 5);
    check("bk_mode", 32'(mode8), 2);

    // Saturation: clr into PRIME, 2 prime edges, then 10 failing checks.
    step(1'b1, 1'b1, 4'h5, 4'h5);
    check("sat_clr_state", 32'(st8), 1);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, (i % 2 == 0) ? 4'hA : 4'h5, (i % 2 == 0) ? 4'hA : 4'h5);
    end
    check("sat_err3", 32'(err3), 7);
    check("sat_chk3", 32'(chk3), 7);
    check("sat_mis3", 32'(mis3), 1);
    check("sat_err8", 32'(err8), 10);
    check("sat_chk8", 32'(chk8), 10);

    // Async reset mid-CHECK after two failures.
    step(1'b1, 1'b1, 4'h1, 4'h1);
    step(1'b1, 1'b0, 4'h2, 4'h2);
    step(1'b1, 1'b0, 4'h3, 4'h3);
    step(1'b1, 1'b0, 4'h4, 4'h4);
    step(1'b1, 1'b0, 4'h5, 4'h5);
    check("pre_rst_err", 32'(err8), 2);
    #28 rst = 1'b1;
    #5;
    check("arst_state", 32'(st8), 0);
    check("arst_err", 32'(err8), 0);
    check("arst_chk", 32'(chk8), 0);
    check("arst_mis", 32'(mis8), 0);
    check("arst_mode", 32'(mode8), 0);
    compare_all();
    rst = 1'b0;
    step(1'b1, 1'b0, 4'h6, 4'h6);
    check("rearm_entry", 32'(st8), 1);
    step(1'b1, 1'b0, 4'h7, 4'h7);
    check("rearm_prime", 32'(st8), 1);
    step(1'b1, 1'b0, 4'h8, 4'h8);
    check("rearm_check", 32'(st8), 2);

    // clr inside CHECK, then en drop inside CHECK.
    step(1'b1, 1'b0, 4'h3, 4'h3);
    step(1'b1, 1'b1, 4'h4, 4'h4);
    check("clr_chk", 32'(chk8), 0);
    check("clr_err", 32'(err8), 0);
    check("clr_mode", 32'(mode8), 0);
    check("clr_state", 32'(st8), 1);
    step(1'b1, 1'b0, 4'h5, 4'h5);
    step(1'b1, 1'b0, 4'h6, 4'h6);
    step(1'b1, 1'b0, 4'h9, 4'h9);
    check("post_clr_err", 32'(err8), 1);
    step(1'b0, 1'b0, 4'h0, 4'h1);
    check("drop_state", 32'(st8), 0);
    check("drop_err", 32'(err8), 1);
    check("drop_chk", 32'(chk8), 1);
    check("drop_mis", 32'(mis8), 0);

    step(1'b0, 1'b0, 4'h0, 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
